fp_round_pipe: RTL and testbench
================================

Name: fp_round_pipe

Overview:
- Parametrised, pipelined successor to the fpcvt combinational rounder.
- Converts a two's-complement integer into sign / exponent / significand form, where value = (-1)^sign * sig * 2^exp.
- Supports runtime-selectable rounding mode, saturation, and inexact/saturate flags.
- Three-stage pipeline with valid/ready handshakes on both sides; sits between the integer source and the float packer.

Parameters:
- IN_W, 12, input integer width (two's complement); must be > SIG_W.
- EXP_W, 3, exponent field width; exp_max = 2^EXP_W-1.
- SIG_W, 4, significand field width; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  IN_W  two's-complement integer.
- in_mode  in  2  rounding mode: 0 truncate, 1 round-half-up (magnitude), 2 round-half-even, 3 reserved (treated as truncate).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sign  out  1  sign of result.
- out_exp  out  EXP_W  exponent.
- out_sig  out  SIG_W  significand.
- out_inexact  out  1  result differs from input value (rounding or saturation).
- out_sat  out  1  result saturated.

Behaviour:
- Reset: all stage valid bits 0; out_valid=0; out_sign, out_exp, out_sig, out_inexact, out_sat all 0. in_ready=1 after reset releases.
- Handshake: a transfer occurs when valid && ready on the same rising edge.
  - Stage k advances when stage k is empty or stage k+1 takes its word: ready_k = !v_k || ready_{k+1}, with ready_4 = out_ready.
  - in_ready = ready_1.
  - Bubbles collapse. Latency is 3 cycles with no backpressure. Throughput is 1 word per cycle.
- Output stability: outputs hold stable while out_valid && !out_ready. Order is preserved. in_mode is captured with in_data and travels with it.
- Stage 1:
  - sign = in_data[IN_W-1].
  - mag = |in_data| as IN_W-bit unsigned; the most negative input gives mag = 2^(IN_W-1).
- Stage 2: let p = index of the leading 1 of mag.
  - If mag = 0 or p < SIG_W: exp = 0, sig = mag[SIG_W-1:0], rbit = 0, sticky = 0.
  - Otherwise: exp = p-SIG_W+1, sig = mag[p:p-SIG_W+1], rbit = mag[p-SIG_W], sticky = OR of mag[p-SIG_W-1:0] (0 if empty).
  - The internal exponent is wide enough to hold IN_W with no truncation.
- Stage 3, rounding increment inc:
  - Mode 0: inc = 0.
  - Mode 1: inc = rbit.
  - Mode 2: inc = rbit && (sticky || sig[0]).
- Stage 3, sig+inc:
  - If sig+inc overflows SIG_W bits: sig = 1 << (SIG_W-1), exp = exp+1.
- Stage 3, saturation:
  - If exp > exp_max after rounding: exp = exp_max, sig = all ones, sat = 1.
- Flags: inexact = rbit || sticky || sat.
- Zero input gives sign 0, exp 0, sig 0, inexact 0.
- Reset mid-operation: all in-flight words are discarded immediately (asynchronous). No output is produced for them.

Test Plan:
- Default params, mode 1, in_data=123 -> sign 0, exp 3, sig 1111, inexact 1, sat 0, out_valid exactly 3 cycles after acceptance.
- in_data=42 in each mode:
  - mode 0 -> exp 2, sig 1010.
  - mode 1 -> exp 2, sig 1011.
  - mode 2 -> exp 2, sig 1010.
  - All three: inexact 1.
- in_data=125, mode 1 -> sig overflow gives exp 4, sig 1000. Same input in mode 0 -> exp 3, sig 1111.
- in_data=14 -> exp 0, sig 1110, inexact 0. in_data=0 -> all zero, inexact 0.
- Saturation cases:
  - in_data=0x800 (-2048) -> sign 1, exp 111, sig 1111, sat 1.
  - in_data=0x7FF, mode 1 -> round overflow saturates, sat 1.
  - in_data=0x7FF, mode 0 -> exp 7, sig 1111, sat 0, inexact 1.
- Backpressure:
  - Hold out_ready=0 and offer 5 back-to-back words -> exactly 3 accepted, then in_ready=0.
  - Release out_ready -> all words emerge in order with no loss or duplication.
- Reset mid-operation:
  - Assert rst_n=0 with 2 words in flight -> out_valid drops immediately.
  - After release, no stale output appears and in_ready=1.

Source files
------------

// File: rtl/fp_round_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_pipe_if
//  Description : Handshake bundle for fp_round_pipe. The integer source
//                drives the input side; the float packer consumes the
//                output side. "slave" is the converter's view, "master"
//                is the view of the agent that feeds and drains it.
//  Revision    : 1.0  initial release
// ============================================================================
interface fp_round_pipe_if #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
) ();

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [1:0]        in_mode;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [SIG_W-1:0]  out_sig;
    logic              out_inexact;
    logic              out_sat;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig,
               out_inexact, out_sat
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig,
               out_inexact, out_sat
    );

endinterface
`default_nettype wire

// File: rtl/fp_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_pipe
//  Description : Three-stage integer-to-float converter.
//                value = (-1)^sign * sig * 2^exp
//                S1: sign / magnitude, S2: normalise + round/sticky bits,
//                S3: rounding, significand overflow and saturation.
//                Valid/ready on both sides, bubbles collapse.
//                Requires IN_W > SIG_W and SIG_W >= 2.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_round_pipe #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int SIG_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fp_round_pipe_if.slave     bus
);

    // Internal exponent must hold both the largest normalise shift
    // (IN_W - SIG_W, plus one for rounding overflow) and EXP_MAX + 1.
    localparam int XW_A    = $clog2(IN_W + 1) + 1;
    localparam int XW      = (XW_A > EXP_W + 1) ? XW_A : EXP_W + 1;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    localparam logic [1:0] MODE_TRUNC = 2'd0;
    localparam logic [1:0] MODE_RHU   = 2'd1;
    localparam logic [1:0] MODE_RHE   = 2'd2;

    // ---------------- stage registers ----------------
    logic              r1_valid, r2_valid, r3_valid;
    logic              r1_sign,  r2_sign,  r3_sign;
    logic [IN_W-1:0]   r1_mag;
    logic [1:0]        r1_mode,  r2_mode;
    logic [XW-1:0]     r2_exp;
    logic [SIG_W-1:0]  r2_sig;
    logic              r2_rbit,  r2_sticky;
    logic [EXP_W-1:0]  r3_exp;
    logic [SIG_W-1:0]  r3_sig;
    logic              r3_inexact, r3_sat;

    // ---------------- handshake ----------------
    logic w_ready1, w_ready2, w_ready3;

    assign w_ready3     = !r3_valid || bus.out_ready;
    assign w_ready2     = !r2_valid || w_ready3;
    assign w_ready1     = !r1_valid || w_ready2;
    assign bus.in_ready = w_ready1;

    // ---------------- stage 1: sign / magnitude ----------------
    logic [IN_W-1:0] w_mag1;

    // Two's-complement negate; the most negative input wraps to 2^(IN_W-1),
    // which is exactly its magnitude when read as unsigned.
    assign w_mag1 = bus.in_data[IN_W-1] ? (~bus.in_data + IN_W'(1)) : bus.in_data;

    // Stage 1 register: capture sign, magnitude and the word's rounding mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_mag   <= '0;
            r1_mode  <= MODE_TRUNC;
        end else if (w_ready1) begin
            r1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r1_sign <= bus.in_data[IN_W-1];
                r1_mag  <= w_mag1;
                r1_mode <= bus.in_mode;
            end
        end
    end

    // ---------------- stage 2: normalise ----------------
    logic [XW-1:0]    w_lead;
    logic [XW-1:0]    w_shamt;
    logic [IN_W-1:0]  w_shifted;
    logic [IN_W-1:0]  w_rsh;
    logic [IN_W-1:0]  w_mask;
    logic [XW-1:0]    w_exp2;
    logic [SIG_W-1:0] w_sig2;
    logic             w_rbit2, w_sticky2;

    // Find the leading one and split the magnitude into kept bits,
    // the round bit just below them and the sticky OR of the remainder.
    always_comb begin
        w_lead    = '0;
        w_shamt   = '0;
        w_shifted = '0;
        w_rsh     = '0;
        w_mask    = '0;
        w_exp2    = '0;
        w_sig2    = r1_mag[SIG_W-1:0];
        w_rbit2   = 1'b0;
        w_sticky2 = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (r1_mag[i]) begin
                w_lead = XW'(i);
            end
        end
        // A zero magnitude leaves w_lead at 0 and takes the small-value path.
        if (w_lead >= XW'(SIG_W)) begin
            w_shamt   = w_lead - XW'(SIG_W) + XW'(1);
            w_exp2    = w_shamt;
            w_shifted = r1_mag >> w_shamt;
            w_sig2    = w_shifted[SIG_W-1:0];
            w_rsh     = r1_mag >> (w_shamt - XW'(1));
            w_rbit2   = w_rsh[0];
            w_mask    = ~({IN_W{1'b1}} << (w_shamt - XW'(1)));
            w_sticky2 = |(r1_mag & w_mask);
        end
    end

    // Stage 2 register: normalised fields plus round/sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid  <= 1'b0;
            r2_sign   <= 1'b0;
            r2_mode   <= MODE_TRUNC;
            r2_exp    <= '0;
            r2_sig    <= '0;
            r2_rbit   <= 1'b0;
            r2_sticky <= 1'b0;
        end else if (w_ready2) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_sign   <= r1_sign;
                r2_mode   <= r1_mode;
                r2_exp    <= w_exp2;
                r2_sig    <= w_sig2;
                r2_rbit   <= w_rbit2;
                r2_sticky <= w_sticky2;
            end
        end
    end

    // ---------------- stage 3: round and saturate ----------------
    logic             w_inc;
    logic [SIG_W:0]   w_sum;
    logic [XW-1:0]    w_exp3;
    logic [SIG_W-1:0] w_sig3;
    logic             w_sat3;
    logic             w_inexact3;

    // Apply the mode's increment, renormalise on carry-out, clamp at EXP_MAX.
    always_comb begin
        w_inc = 1'b0;
        case (r2_mode)
            MODE_RHU: w_inc = r2_rbit;
            MODE_RHE: w_inc = r2_rbit && (r2_sticky || r2_sig[0]);
            default:  w_inc = 1'b0;
        endcase
        w_sum  = {1'b0, r2_sig} + (SIG_W + 1)'(w_inc);
        w_exp3 = r2_exp;
        w_sig3 = w_sum[SIG_W-1:0];
        if (w_sum[SIG_W]) begin
            w_sig3 = SIG_W'(1) << (SIG_W - 1);
            w_exp3 = r2_exp + XW'(1);
        end
        w_sat3 = (w_exp3 > XW'(EXP_MAX));
        if (w_sat3) begin
            w_exp3 = XW'(EXP_MAX);
            w_sig3 = '1;
        end
        w_inexact3 = r2_rbit || r2_sticky || w_sat3;
    end

    // Stage 3 register: the output word; held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid   <= 1'b0;
            r3_sign    <= 1'b0;
            r3_exp     <= '0;
            r3_sig     <= '0;
            r3_inexact <= 1'b0;
            r3_sat     <= 1'b0;
        end else if (w_ready3) begin
            r3_valid <= r2_valid;
            if (r2_valid) begin
                r3_sign    <= r2_sign;
                r3_exp     <= w_exp3[EXP_W-1:0];
                r3_sig     <= w_sig3;
                r3_inexact <= w_inexact3;
                r3_sat     <= w_sat3;
            end
        end
    end

    assign bus.out_valid   = r3_valid;
    assign bus.out_sign    = r3_sign;
    assign bus.out_exp     = r3_exp;
    assign bus.out_sig     = r3_sig;
    assign bus.out_inexact = r3_inexact;
    assign bus.out_sat     = r3_sat;

endmodule
`default_nettype wire

// File: tb/tb_fp_round_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_round_pipe
//  Description : Directed self-checking bench for fp_round_pipe with
//                hand-computed expected results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_round_pipe;

    localparam int IN_W  = 12;
    localparam int EXP_W = 3;
    localparam int SIG_W = 4;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    fp_round_pipe_if #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) bus ();

    fp_round_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    typedef struct {
        logic [11:0] data;
        logic [1:0]  mode;
        logic        sign;
        logic [2:0]  exp_f;
        logic [3:0]  sig;
        logic        inexact;
        logic        sat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{12'd123,  2'd1, 1'b0, 3'd3, 4'hF, 1'b1, 1'b0};
        vecs[1]  = '{12'd42,   2'd0, 1'b0, 3'd2, 4'hA, 1'b1, 1'b0};
        vecs[2]  = '{12'd42,   2'd1, 1'b0, 3'd2, 4'hB, 1'b1, 1'b0};
        vecs[3]  = '{12'd42,   2'd2, 1'b0, 3'd2, 4'hA, 1'b1, 1'b0};
        vecs[4]  = '{12'd42,   2'd3, 1'b0, 3'd2, 4'hA, 1'b1, 1'b0};
        vecs[5]  = '{12'd125,  2'd1, 1'b0, 3'd4, 4'h8, 1'b1, 1'b0};
        vecs[6]  = '{12'd125,  2'd0, 1'b0, 3'd3, 4'hF, 1'b1, 1'b0};
        vecs[7]  = '{12'd14,   2'd1, 1'b0, 3'd0, 4'hE, 1'b0, 1'b0};
        vecs[8]  = '{12'd0,    2'd2, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0};
        vecs[9]  = '{12'h800,  2'd0, 1'b1, 3'd7, 4'hF, 1'b1, 1'b1};
        vecs[10] = '{12'h7FF,  2'd1, 1'b0, 3'd7, 4'hF, 1'b1, 1'b1};
        vecs[11] = '{12'h7FF,  2'd0, 1'b0, 3'd7, 4'hF, 1'b1, 1'b0};
        vecs[12] = '{12'hFD6,  2'd1, 1'b1, 3'd2, 4'hB, 1'b1, 1'b0}; // -42
        vecs[13] = '{12'd46,   2'd2, 1'b0, 3'd2, 4'hC, 1'b1, 1'b0}; // tie, odd sig
    end

    // Present one word, count rising edges from acceptance until out_valid.
    task automatic run_vec(input int idx);
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = vecs[idx].data;
        bus.in_mode  = vecs[idx].mode;
        bus.out_ready = 1'b1;
        #1;
        check_eq($sformatf("in_ready[%0d]", idx), 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq($sformatf("latency[%0d]", idx), 32'(lat),             32'd3);
        check_eq($sformatf("sign[%0d]", idx),    32'(bus.out_sign),    32'(vecs[idx].sign));
        check_eq($sformatf("exp[%0d]", idx),     32'(bus.out_exp),     32'(vecs[idx].exp_f));
        check_eq($sformatf("sig[%0d]", idx),     32'(bus.out_sig),     32'(vecs[idx].sig));
        check_eq($sformatf("inexact[%0d]", idx), 32'(bus.out_inexact), 32'(vecs[idx].inexact));
        check_eq($sformatf("sat[%0d]", idx),     32'(bus.out_sat),     32'(vecs[idx].sat));
        @(posedge clk);
        #1;
        check_eq($sformatf("drain[%0d]", idx), 32'(bus.out_valid), 32'd0);
    endtask

    logic [11:0] bp_words[5];
    int          n_acc;
    int          n_rx;
    int          n_stale;

    initial begin
        n_cmp = 0;
        n_err = 0;
        bp_words[0] = 12'd3;
        bp_words[1] = 12'd5;
        bp_words[2] = 12'd7;
        bp_words[3] = 12'd9;
        bp_words[4] = 12'd11;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 2'd0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst out_valid",   32'(bus.out_valid),   32'd0);
        check_eq("rst out_sign",    32'(bus.out_sign),    32'd0);
        check_eq("rst out_exp",     32'(bus.out_exp),     32'd0);
        check_eq("rst out_sig",     32'(bus.out_sig),     32'd0);
        check_eq("rst out_inexact", 32'(bus.out_inexact), 32'd0);
        check_eq("rst out_sat",     32'(bus.out_sat),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst in_ready", 32'(bus.in_ready), 32'd1);

        // Directed conversion vectors
        for (int i = 0; i < 14; i++) begin
            run_vec(i);
        end

        // Backpressure: stalled output, five words offered back to back
        n_acc = 0;
        n_rx  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = (n_acc < 5);
            bus.in_data   = bp_words[n_acc < 5 ? n_acc : 4];
            bus.in_mode   = 2'd0;
            #1;
            if (bus.in_valid && bus.in_ready) begin
                @(posedge clk);
                n_acc++;
            end else begin
                @(posedge clk);
            end
        end
        #1;
        check_eq("bp accepted", 32'(n_acc), 32'd3);
        check_eq("bp in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("bp out_valid held", 32'(bus.out_valid), 32'd1);
        check_eq("bp held sig", 32'(bus.out_sig), 32'(bp_words[0][3:0]));

        // Release and drain in order
        for (int c = 0; c < 40 && n_rx < 5; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (n_acc < 5);
            bus.in_data   = bp_words[n_acc < 5 ? n_acc : 4];
            #1;
            if (bus.out_valid) begin
                if (n_rx < 5) begin
                    check_eq($sformatf("bp order sig[%0d]", n_rx), 32'(bus.out_sig),
                             32'(bp_words[n_rx][3:0]));
                end
                n_rx++;
            end
            if (bus.in_valid && bus.in_ready) begin
                n_acc++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) n_rx++;
        end
        check_eq("bp received", 32'(n_rx), 32'd5);

        // Reset with two words in flight
        n_acc = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = 12'd100 + 12'(c);
            #1;
            if (bus.in_ready) n_acc++;
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst2 accepted", 32'(n_acc), 32'd2);
        check_eq("rst2 pre valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst2 out_valid drop", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check_eq("rst2 in_ready", 32'(bus.in_ready), 32'd1);
        n_stale = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) n_stale++;
        end
        check_eq("rst2 stale outputs", 32'(n_stale), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
